// File: rtl/store_merge_rmw.sv
// Store merge unit: byte/half/word/dword stores onto a word-wide memory port via read-modify-write.
// Optional alignment check enabled by defining STORE_MERGE_ALIGN_CHK_EN.
module store_merge_rmw #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              st_valid_i,
  output logic              st_ready_o,
  input  logic [ADDR_W-1:0] st_addr_i,
  input  logic [1:0]        st_size_i,
  input  logic [DATA_W-1:0] st_data_i,
  output logic              st_done_o,
  output logic              st_err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam logic [1:0] FULL_SZ = (DATA_W == 64) ? 2'd3 : 2'd2;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_MERGE = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] mdr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [1:0]        eff_size;
  logic              accept;
  logic              full_st;
  logic [OFF_W-1:0]  off;

  // Offset bits that must be zero for a store of the given size to be naturally aligned.
  function automatic logic [OFF_W-1:0] lane_mask(input logic [1:0] size);
    logic [OFF_W-1:0] m;
    m = '0;
    for (int b = 0; b < OFF_W; b++) begin
      if (b < int'(size)) m[b] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [DATA_W-1:0] merge_lanes(input logic [DATA_W-1:0] mdr,
                                                    input logic [DATA_W-1:0] data,
                                                    input logic [OFF_W-1:0]  lane_off,
                                                    input logic [1:0]        size);
    logic [DATA_W-1:0] res;
    int lo;
    int hi;
    res = mdr;
    lo  = int'(lane_off);
    hi  = lo + (1 << size);
    for (int i = 0; i < NB; i++) begin
      if (i >= lo && i < hi) res[8*i +: 8] = data[8*(i-lo) +: 8];
    end
    return res;
  endfunction

  // A dword request on a 32-bit port degrades to a word store.
  always_comb begin
    eff_size = st_size_i;
    if (DATA_W == 32 && st_size_i == 2'd3) eff_size = 2'd2;
  end

  assign accept  = st_valid_i && (state_q == S_IDLE);
  assign full_st = (eff_size == FULL_SZ);
  assign off     = addr_q[OFF_W-1:0] & ~lane_mask(size_q);

`ifdef STORE_MERGE_ALIGN_CHK_EN
  logic misalign;
  logic err_q;

  assign misalign = |(st_addr_i[OFF_W-1:0] & lane_mask(eff_size));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= misalign;
    end
  end

  assign st_err_o = err_q && (state_q == S_DONE);
`else
  assign st_err_o = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (st_valid_i) begin
`ifdef STORE_MERGE_ALIGN_CHK_EN
          if (misalign)     state_d = S_DONE;
          else if (full_st) state_d = S_WRITE;
          else              state_d = S_READ;
`else
          if (full_st) state_d = S_WRITE;
          else         state_d = S_READ;
`endif
        end
      end
      S_READ:  if (mem_ack_i) state_d = S_MERGE;
      S_MERGE: state_d = S_WRITE;
      S_WRITE: if (mem_ack_i) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request capture; full-width stores load the write word directly and never visit MERGE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q  <= '0;
      size_q  <= '0;
      data_q  <= '0;
      mdr_q   <= '0;
      wdata_q <= '0;
    end else begin
      if (accept) begin
        addr_q <= st_addr_i;
        size_q <= eff_size;
        data_q <= st_data_i;
        if (full_st) wdata_q <= st_data_i;
      end
      if (state_q == S_READ && mem_ack_i) mdr_q <= mem_rdata_i;
      if (state_q == S_MERGE) wdata_q <= merge_lanes(mdr_q, data_q, off, size_q);
    end
  end

  // Outputs decode straight from state so a reset drops mem_req without waiting for a clock.
  assign st_ready_o  = (state_q == S_IDLE);
  assign st_done_o   = (state_q == S_DONE);
  assign mem_req_o   = (state_q == S_READ) || (state_q == S_WRITE);
  assign mem_we_o    = (state_q == S_WRITE);
  assign mem_addr_o  = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_store_merge_rmw.sv
// Bench for store_merge_rmw: a 32-bit and a 64-bit instance share one stimulus/memory model via sel.
module tb_store_merge_rmw;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [63:0] data;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] s_addr;
  logic [1:0]  s_size;
  logic [63:0] s_data;
  logic        s_valid;
  logic [63:0] mem_word;
  int          sel;
  int          waits;
  int          wcnt;
  int          unstable;
  int          checks;
  int          errors;

  logic        in_req;
  logic        f_we;
  logic [31:0] f_addr;
  logic [63:0] f_wd;
  txn_t        act_q[$];
  txn_t        exp_q[$];

  logic        vld32, rdy32, done32, err32, req32, we32, ack32;
  logic [31:0] maddr32, wd32;
  logic        vld64, rdy64, done64, err64, req64, we64, ack64;
  logic [31:0] maddr64;
  logic [63:0] wd64;

  logic        rdy, done, err, req, we, ack;
  logic [31:0] maddr;
  logic [63:0] wdata;

  always #5 clk = ~clk;

  assign vld32 = s_valid && (sel == 0);
  assign vld64 = s_valid && (sel == 1);
  assign rdy   = (sel == 1) ? rdy64   : rdy32;
  assign done  = (sel == 1) ? done64  : done32;
  assign err   = (sel == 1) ? err64   : err32;
  assign req   = (sel == 1) ? req64   : req32;
  assign we    = (sel == 1) ? we64    : we32;
  assign maddr = (sel == 1) ? maddr64 : maddr32;
  assign wdata = (sel == 1) ? wd64    : {32'h0, wd32};
  assign ack   = req && (wcnt == waits);
  assign ack32 = ack && (sel == 0);
  assign ack64 = ack && (sel == 1);

  store_merge_rmw #(.DATA_W(32), .ADDR_W(32)) dut32 (
    .clk_i(clk), .rst_ni(rst_n),
    .st_valid_i(vld32), .st_ready_o(rdy32), .st_addr_i(s_addr), .st_size_i(s_size),
    .st_data_i(s_data[31:0]), .st_done_o(done32), .st_err_o(err32),
    .mem_req_o(req32), .mem_we_o(we32), .mem_addr_o(maddr32), .mem_wdata_o(wd32),
    .mem_rdata_i(mem_word[31:0]), .mem_ack_i(ack32)
  );

  store_merge_rmw #(.DATA_W(64), .ADDR_W(32)) dut64 (
    .clk_i(clk), .rst_ni(rst_n),
    .st_valid_i(vld64), .st_ready_o(rdy64), .st_addr_i(s_addr), .st_size_i(s_size),
    .st_data_i(s_data), .st_done_o(done64), .st_err_o(err64),
    .mem_req_o(req64), .mem_we_o(we64), .mem_addr_o(maddr64), .mem_wdata_o(wd64),
    .mem_rdata_i(mem_word), .mem_ack_i(ack64)
  );

  // Memory model: acks after `waits` stall cycles, logs every completed transfer, flags unstable requests.
  always @(posedge clk) begin
    if (!rst_n) begin
      wcnt   <= 0;
      in_req <= 1'b0;
    end else if (req) begin
      if (!in_req) begin
        f_we   <= we;
        f_addr <= maddr;
        f_wd   <= wdata;
        in_req <= 1'b1;
      end else if (we !== f_we || maddr !== f_addr || wdata !== f_wd) begin
        unstable = unstable + 1;
      end
      if (ack) begin
        act_q.push_back('{we, maddr, (we ? wdata : 64'h0)});
        wcnt   <= 0;
        in_req <= 1'b0;
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      wcnt   <= 0;
      in_req <= 1'b0;
    end
  end

  function automatic logic [63:0] ref_merge(input logic [63:0] word, input logic [31:0] a,
                                            input int sz, input logic [63:0] d, input int nbytes);
    logic [63:0] r;
    int n;
    int o;
    r = word;
    n = 1 << sz;
    o = (int'(a[2:0]) % nbytes) / n * n;
    for (int i = 0; i < n; i++) r[8*(o+i) +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic do_store(input int s, input logic [31:0] a, input logic [1:0] sz,
                          input logic [63:0] d, input logic [63:0] word, input int w,
                          input logic [63:0] exp_wd, input bit exp_rd, input bit exp_wr,
                          input bit exp_err, input int exp_cyc, input bit hold, input string nm);
    int cyc;
    bit seen;
    int rdy_bad;
    int start;
    int u0;
    int idx;
    logic [31:0] base;
    txn_t e;
    txn_t g;
    @(posedge clk); #1;
    sel      = s;
    mem_word = word;
    waits    = w;
    start    = act_q.size();
    u0       = unstable;
    base     = a & ~((s == 1) ? 32'd7 : 32'd3);
    if (exp_rd) exp_q.push_back('{1'b0, base, 64'h0});
    if (exp_wr) exp_q.push_back('{1'b1, base, exp_wd});
    checks++;
    if (rdy !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_idle: got %b expected 1", nm, rdy);
    end
    s_addr  = a;
    s_size  = sz;
    s_data  = d;
    s_valid = 1'b1;
    @(posedge clk); #1;
    if (!hold) s_valid = 1'b0;
    cyc     = 2;
    seen    = 1'b0;
    rdy_bad = 0;
    while (!seen && cyc < 200) begin
      if (done === 1'b1) begin
        seen = 1'b1;
      end else begin
        if (rdy !== 1'b0) rdy_bad++;
        @(posedge clk); #1;
        cyc++;
      end
    end
    s_valid = 1'b0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s timeout: no st_done within %0d cycles, expected at %0d", nm, cyc, exp_cyc);
    end else begin
      checks++;
      if (cyc != exp_cyc) begin
        errors++;
        $display("FAIL %s latency: got %0d cycles expected %0d", nm, cyc, exp_cyc);
      end
      checks++;
      if (err !== exp_err) begin
        errors++;
        $display("FAIL %s st_err: got %b expected %b", nm, err, exp_err);
      end
    end
    if (hold) begin
      checks++;
      if (rdy_bad != 0) begin
        errors++;
        $display("FAIL %s ready_busy: ready high in %0d busy cycles, expected 0", nm, rdy_bad);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (rdy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s back_to_idle: ready=%b done=%b expected ready=1 done=0", nm, rdy, done);
    end
    checks++;
    if (act_q.size() - start != exp_q.size()) begin
      errors++;
      $display("FAIL %s txn_count: got %0d expected %0d", nm, act_q.size() - start, exp_q.size());
    end
    idx = start;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (idx < act_q.size()) begin
        g = act_q[idx];
        checks++;
        if (g !== e) begin
          errors++;
          $display("FAIL %s txn%0d: got we=%b addr=%h data=%h expected we=%b addr=%h data=%h",
                   nm, idx - start, g.we, g.addr, g.data, e.we, e.addr, e.data);
        end
      end
      idx++;
    end
    checks++;
    if (unstable != u0) begin
      errors++;
      $display("FAIL %s mem_stable: %0d unstable cycles, expected 0", nm, unstable - u0);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (rdy32 !== 1'b1 || rdy64 !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b/%b expected 1/1", rdy32, rdy64);
    end
    checks++;
    if ({done32, err32, req32, we32, done64, err64, req64, we64} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 00000000",
               {done32, err32, req32, we32, done64, err64, req64, we64});
    end
    checks++;
    if (maddr32 !== 32'h0 || wd32 !== 32'h0 || maddr64 !== 32'h0 || wd64 !== 64'h0) begin
      errors++;
      $display("FAIL reset_data: got %h %h %h %h expected all 0", maddr32, wd32, maddr64, wd64);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_byte();
    do_store(0, 32'h1003, 2'd0, 64'hAB, 64'h11223344, 0, 64'hAB223344, 1, 1, 0, 5, 0, "byte32");
  endtask

  task automatic test_half();
    do_store(0, 32'h2002, 2'd1, 64'hBEEF, 64'hCAFE0000, 0, 64'hBEEF0000, 1, 1, 0, 5, 0, "half32_hi");
    do_store(0, 32'h2000, 2'd1, 64'hBEEF, 64'hCAFE0000, 0, 64'hCAFEBEEF, 1, 1, 0, 5, 0, "half32_lo");
  endtask

  task automatic test_back_to_back();
    do_store(0, 32'h3000, 2'd2, 64'hDEADBEEF, 64'h0, 0, 64'hDEADBEEF, 0, 1, 0, 3, 1, "word32_hold");
    do_store(0, 32'h3004, 2'd3, 64'h0123456789ABCDEF, 64'h0, 0, 64'h89ABCDEF, 0, 1, 0, 3, 0, "dword_on_32");
  endtask

  task automatic test_dw64();
    do_store(1, 32'h5005, 2'd0, 64'h7F, 64'h0011223344556677, 0, 64'h00117F3344556677,
             1, 1, 0, 5, 0, "byte64");
    do_store(1, 32'h5006, 2'd1, 64'hBEEF, 64'h0011223344556677, 0, 64'hBEEF223344556677,
             1, 1, 0, 5, 0, "half64");
    do_store(1, 32'h6008, 2'd3, 64'h0123456789ABCDEF, 64'hFFFFFFFFFFFFFFFF, 0, 64'h0123456789ABCDEF,
             0, 1, 0, 3, 0, "dword64");
  endtask

  task automatic test_wait_states();
    do_store(0, 32'h1001, 2'd0, 64'h5A, 64'h11223344, 4, 64'h11225A44, 1, 1, 0, 13, 0, "byte32_wait4");
    do_store(1, 32'h7004, 2'd2, 64'hA5A5A5A5, 64'h1111111122222222, 4, 64'hA5A5A5A522222222,
             1, 1, 0, 13, 0, "word64_wait4");
  endtask

  task automatic test_misalign();
`ifdef STORE_MERGE_ALIGN_CHK_EN
    do_store(0, 32'h4001, 2'd1, 64'h1234, 64'hAAAAAAAA, 0, 64'h0, 0, 0, 1, 2, 0, "misalign_half");
`else
    do_store(0, 32'h4001, 2'd1, 64'h1234, 64'hAAAAAAAA, 0, 64'hAAAA1234, 1, 1, 0, 5, 0, "misalign_half");
`endif
  endtask

  task automatic test_random();
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 6; k++) begin
        int sz;
        int w;
        int nb;
        bit full;
        logic [31:0] a;
        logic [63:0] d;
        logic [63:0] word;
        logic [63:0] ex;
        nb   = (s == 1) ? 8 : 4;
        sz   = $urandom_range((s == 1) ? 3 : 2, 0);
        a    = $urandom() & ~((32'd1 << sz) - 32'd1);
        d    = {$urandom(), $urandom()};
        word = (s == 1) ? {$urandom(), $urandom()} : {32'h0, $urandom()};
        w    = $urandom_range(2, 0);
        full = (sz == ((s == 1) ? 3 : 2));
        if (full) ex = (s == 1) ? d : {32'h0, d[31:0]};
        else      ex = ref_merge(word, a, sz, d, nb);
        do_store(s, a, 2'(sz), d, word, w, ex, !full, 1'b1, 1'b0,
                 full ? 3 + w : 5 + 2 * w, 1'b0, "random");
      end
    end
  endtask

  task automatic test_reset_abort();
    int n;
    int start;
    int bad_done;
    int wr_seen;
    @(posedge clk); #1;
    sel      = 0;
    waits    = 4;
    mem_word = 64'h99887766;
    start    = act_q.size();
    s_addr   = 32'h7001;
    s_size   = 2'd0;
    s_data   = 64'h55;
    s_valid  = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    n = 0;
    while (!(req === 1'b1 && we === 1'b1) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL abort_reach_write: WRITE not reached in %0d cycles", n);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (req !== 1'b0 || we !== 1'b0 || rdy !== 1'b1) begin
      errors++;
      $display("FAIL abort_async: req=%b we=%b ready=%b expected 0 0 1", req, we, rdy);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n    = 1'b1;
    bad_done = 0;
    for (int i = 0; i < 10; i++) begin
      if (done !== 1'b0 || req !== 1'b0) bad_done++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad_done != 0) begin
      errors++;
      $display("FAIL abort_quiet: done/req seen in %0d cycles after reset, expected 0", bad_done);
    end
    wr_seen = 0;
    for (int i = start; i < act_q.size(); i++) if (act_q[i].we) wr_seen++;
    checks++;
    if (wr_seen != 0) begin
      errors++;
      $display("FAIL abort_no_write: got %0d completed writes expected 0", wr_seen);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    unstable = 0;
    rst_n    = 1'b0;
    s_valid  = 1'b0;
    s_addr   = '0;
    s_size   = '0;
    s_data   = '0;
    sel      = 0;
    waits    = 0;
    mem_word = '0;
    test_reset();
    test_byte();
    test_half();
    test_back_to_back();
    test_dw64();
    test_wait_states();
    test_misalign();
    test_random();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/store_merge_rmw.md
Name: store_merge_rmw

Overview:
- Parametrised successor to the fixed halfword MDR merge.
- Accepts byte, half, word (and doubleword when DATA_W=64) stores from the CPU datapath.
- Sub-word stores run a read-modify-write on the word-wide memory port; full-width stores bypass the read.
- Sits between the CPU store stage and the data memory/bus interface.

Parameters:
- DATA_W, 32, memory word width in bits; legal values 32 or 64.
- ADDR_W, 32, byte-address width.
- OFF_W, log2(DATA_W/8), byte-offset bits within a word (derived localparam, not overridable).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- st_valid  in  1  store request valid.
- st_ready  out  1  block idle and accepting a request.
- st_addr  in  ADDR_W  byte address of the store.
- st_size  in  2  0=byte, 1=half, 2=word32, 3=dword64. Code 3 with DATA_W=32 is treated as 2.
- st_data  in  DATA_W  store data, right-justified (LSBs valid).
- st_done  out  1  one-cycle pulse when the store completes.
- st_err  out  1  misalignment flag, valid with st_done. Tied 0 without the feature macro.
- mem_req  out  1  memory request; held high until mem_ack.
- mem_we  out  1  1=write, 0=read; stable while mem_req is high.
- mem_addr  out  ADDR_W  word-aligned address; low OFF_W bits are always 0.
- mem_wdata  out  DATA_W  merged write word.
- mem_rdata  in  DATA_W  read data, valid when mem_ack is high on a read.
- mem_ack  in  1  one-cycle completion from memory.

Behaviour:
- Reset values (asynchronous, take effect immediately on rst_n low):
  - All outputs 0 except st_ready=1.
  - State=IDLE; internal mdr, addr, size and data registers cleared.
- Handshake:
  - st_ready=1 only in IDLE.
  - A request is accepted on a rising edge with st_valid&&st_ready; the block registers addr, size and data.
  - st_valid while busy is ignored, with no queuing.
- FSM states: IDLE, READ, MERGE, WRITE, DONE.
  - IDLE -> WRITE on accept when size equals the full width (word for DATA_W=32, dword for DATA_W=64). mem_wdata=st_data.
  - IDLE -> READ on accept for any narrower size.
  - READ: mem_req=1, mem_we=0. On mem_ack, capture mem_rdata into mdr and go to MERGE.
  - MERGE: one cycle. Merged word = mdr with the byte lanes at offset, width 2^size bytes, replaced by st_data LSBs; all other lanes are kept from mdr. Go to WRITE.
  - WRITE: mem_req=1, mem_we=1, mem_wdata=merged word. On mem_ack go to DONE.
  - DONE: st_done=1 for one cycle, then IDLE.
- Offset rules:
  - offset = addr[OFF_W-1:0] with the low size bits forced to 0, so a misaligned address is truncated down to its natural alignment.
  - mem_addr = {addr[ADDR_W-1:OFF_W], OFF_W'b0}.
- Latency with mem_ack returned in the first request cycle:
  - Full-width store: accept -> st_done in 3 cycles.
  - Sub-word store: accept -> st_done in 5 cycles.
- Memory wait states hold the FSM in READ/WRITE; all mem_* outputs stay stable until mem_ack.
- mem_ack arriving outside READ/WRITE is ignored.
- Reset mid-operation aborts immediately: mem_req drops asynchronously and no st_done is generated.

Optional Feature:
- Macro: STORE_MERGE_ALIGN_CHK_EN.
- Defined: a misaligned request (addr[size-1:0]!=0 for size>0) goes IDLE -> DONE directly. No memory access occurs; st_done=1 and st_err=1 in the same cycle.
- Undefined: st_err is constant 0 and misaligned addresses are truncated as above.

Test Plan:
- DATA_W=32, mem_ack in the first cycle. Byte store: addr=0x1003, data=0xAB, memory word=0x11223344 -> one read at 0x1000, then write 0xAB223344. st_done exactly 5 cycles after accept.
- Half store: addr=0x2002, data=0xBEEF, word=0xCAFE0000 -> write 0xBEEF0000. Repeat at addr=0x2000 -> write 0xCAFEBEEF.
- Word store: addr=0x3000, data=0xDEADBEEF -> no read issued, write 0xDEADBEEF, st_done 3 cycles after accept. st_valid held high during busy -> st_ready=0 and only one store is performed.
- DATA_W=64, byte store at addr 0x...5 with data 0x7F -> only byte lane 5 of the 64-bit word changes. Dword store -> no read issued.
- Memory inserts 4 wait cycles on both read and write -> mem_req, mem_addr and mem_wdata stable throughout; correct merge; st_done after the second ack. rst_n pulsed low during WRITE -> mem_req=0 immediately, st_ready=1, no st_done.
- With STORE_MERGE_ALIGN_CHK_EN: half store at addr=0x4001 -> no mem_req, st_done=st_err=1 one cycle after accept. Without the macro, the same request writes lanes 0-1 and st_err=0.
